// File: rtl/rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// rr_lock_arbiter
//
// Four-requester round-robin lock arbiter. A requester raises req[i] and
// holds it for as long as it uses the shared resource; dropping it releases
// the lock. Ownership is granted one requester at a time. There is always at
// least one idle cycle between successive grants. After each release the
// search for the next owner starts just past the previous owner.
//
// Optional feature (macro RR_LOCK_ARBITER_TIMEOUT_EN):
//   A hold watchdog revokes the lock once an owner has held it for
//   TIMEOUT_CYCLES cycles. The revoked requester is then masked, which makes
//   it ineligible until it drops its request for at least one cycle. Without
//   the macro, timeout is tied low, the mask stays zero, and the counter is
//   not built.
//
// Parameters:
//   TIMEOUT_CYCLES - maximum cycles one owner may hold the lock (2..65535)
//
// Ports:
//   clk     - single clock, all logic on its rising edge
//   rst     - synchronous active-high reset
//   req     - [3:0] per-requester lock request, held for the whole use
//   grant   - [3:0] registered one-hot lock ownership
//   busy    - OR of grant
//   owner   - [1:0] index of the current (or last) owner
//   timeout - one-cycle pulse when the watchdog revokes the lock
// ---------------------------------------------------------------------------
module rr_lock_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       busy,
  output logic [1:0] owner,
  output logic       timeout
);

  // Reject an out-of-range parameter when the design is elaborated.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rr_lock_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [3:0] mask_q,  mask_d;

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  logic [3:0] eligible;
  logic       owner_req;
  logic [1:0] cand;
  logic [1:0] win_idx;
  logic       win_found;

  assign eligible  = req & ~mask_q;
  assign owner_req = req[owner_q];

  // Round-robin pick: walk ptr, ptr+1, ... and keep the first eligible
  // index. The 2-bit candidate wraps modulo 4 by itself.
  always_comb begin
    cand      = ptr_q;
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && eligible[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic. While the lock is held, a release takes priority over
  // watchdog expiry. An owner that drops req on the expiry edge is
  // therefore treated as a clean release: no timeout pulse and no mask bit.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    // A mask bit clears on any edge where that requester is not requesting.
    mask_d    = mask_q & req;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`else
    mask_d    = 4'b0000;
`endif

    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (win_found) begin
          state_d = HOLD;
          grant_d = 4'b0001 << win_idx;
          owner_d = win_idx;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end

      HOLD: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = owner_q + 2'd1;
        end
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          grant_d         = 4'b0000;
          ptr_d           = owner_q + 2'd1;
          mask_d[owner_q] = 1'b1;
          timeout_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
    endcase
  end

  // State register. Reset wins over every other event, including a release
  // or an expiry in the same cycle. Clearing ptr makes the first arbitration
  // after reset favour requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      mask_q    <= 4'b0000;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign owner = owner_q;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
